muldiv_sequencer: RTL

Multi-cycle sequencer for the RV32M multiply/divide extension, sitting beside the ALU in the execute stage. When the decoder flags an M-type instruction, the block captures the operands, runs a radix-2 shift-add multiply or restoring divide over WIDTH iterations, and stalls the pipeline until the result is ready. It owns its own accumulator and counter and does not use the ALU datapath.

---
 rtl/muldiv_sequencer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit sitting beside the execute-stage ALU.
// Latency: WIDTH cycles from the accepting edge to the done pulse (1 cycle for trivial ops with MULDIV_FAST_PATH_EN).
// Backpressure: stall holds the pipeline while an op is being accepted or computed; start during CALC is ignored.
// Ports: clk, reset (async, active-high); start/funct3/op_a/op_b in;
//        stall (combinational), busy/done/result (registered) out.
// Config: MULDIV_FAST_PATH_EN retires divide-by-zero, signed overflow and zero-operand multiplies from IDLE.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, CALC} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        count;
    logic [2*WIDTH-1:0]   acc;         // multiply: {hi, multiplier}; divide: {rem, quot}
    logic [WIDTH-1:0]     divisor;     // |op_b|: multiplicand or divisor
    logic [2:0]           op_q;
    logic                 neg_q;
    logic                 spec_q;
    logic [WIDTH-1:0]     spec_val_q;

    // Decode of the incoming instruction (only meaningful in IDLE).
    logic             in_div, a_signed, b_signed, sign_a, sign_b, in_neg;
    logic             div_zero, sgn_ovf, in_special, fast_take;
    logic [WIDTH-1:0] abs_a, abs_b, special_value;

    assign in_div   = funct3[2];
    assign a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign sign_a   = a_signed && op_a[WIDTH-1];
    assign sign_b   = b_signed && op_b[WIDTH-1];
    assign abs_a    = sign_a ? -op_a : op_a;
    assign abs_b    = sign_b ? -op_b : op_b;
    // Remainders take the dividend's sign; everything else the product/quotient sign.
    assign in_neg   = (in_div && funct3[1]) ? sign_a : (sign_a ^ sign_b);

    assign div_zero   = in_div && (op_b == '0);
    assign sgn_ovf    = in_div && !funct3[0] && (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&op_b);
    assign in_special = div_zero || sgn_ovf;

    always_comb begin
        special_value = '0;
        if (div_zero)
            special_value = funct3[1] ? op_a : '1;
        else if (sgn_ovf)
            special_value = funct3[1] ? '0 : op_a;
    end

`ifdef MULDIV_FAST_PATH_EN
    assign fast_take = in_special || (!in_div && ((op_a == '0) || (op_b == '0)));
`else
    assign fast_take = 1'b0;
`endif

    // One radix-2 step. The multiplier sits in the low half of acc, so the
    // product is formed as |op_a| * |op_b| (commutative, same result).
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH-1:0]     rem_sub;
    logic                 q_bit;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   acc_next;

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, divisor} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};
    // Shifted remainder needs one extra bit; the difference always fits in WIDTH.
    assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    assign q_bit    = (rem_sh >= {1'b0, divisor});
    assign rem_sub  = rem_sh[WIDTH-1:0] - divisor;
    assign div_next = {(q_bit ? rem_sub : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], q_bit};
    assign acc_next = op_q[2] ? div_next : mul_next;

    // Final value, computed from the last iteration on the completion edge.
    logic [2*WIDTH-1:0] prod_fin;
    logic [WIDTH-1:0]   quot_fin, rem_fin, final_value;

    always_comb begin
        prod_fin    = neg_q ? -mul_next : mul_next;
        quot_fin    = neg_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
        rem_fin     = neg_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
        final_value = '0;
        case (op_q)
            3'b000:                 final_value = prod_fin[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: final_value = prod_fin[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         final_value = quot_fin;
            default:                final_value = rem_fin;
        endcase
        if (spec_q)
            final_value = spec_val_q;
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                stall = start;
                if (start && !fast_take)
                    state_nxt = CALC;
            end
            CALC: begin
                stall = 1'b1;
                if (count == '0)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == CALC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= '0;
            acc        <= '0;
            divisor    <= '0;
            op_q       <= '0;
            neg_q      <= 1'b0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
            done       <= 1'b0;
            result     <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    if (fast_take) begin
                        result <= in_special ? special_value : '0;
                        done   <= 1'b1;
                    end else begin
                        op_q       <= funct3;
                        neg_q      <= in_neg;
                        spec_q     <= in_special;
                        spec_val_q <= special_value;
                        divisor    <= abs_b;
                        acc        <= {{WIDTH{1'b0}}, abs_a};
                        count      <= CW'(WIDTH - 1);
                    end
                end
            end else begin
                acc <= acc_next;
                if (count == '0) begin
                    result <= final_value;
                    done   <= 1'b1;
                end else begin
                    count <= count - CW'(1);
                end
            end
        end
    end
endmodule
